pool_window_ctrl: RTL and testbench
===================================

# pool_window_ctrl

Sequencer for the streaming K×K max-pool datapath. It tracks channel, column and row position of a channel-interleaved pixel stream and issues per-sample control strobes: accumulator load, line-buffer read/write with address, and emit. It also generates output framing (sop/eop/sof/eof) for the pooled stream. It replaces the ad-hoc counters inside each max-pool stage, so the datapath only holds compare/select logic and RAM/FIFO.

## Interface
- CHANNEL_NUM, 3, channels interleaved per pixel (≥1)
- IMG_WIDTH, 8, input pixels per line (≥POOL_K)
- IMG_HEIGHT, 8, input lines per frame (≥POOL_K)
- POOL_K, 2, window size and stride (2..7)
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_i  in  1  input sample valid; no backpressure
- sof_i  in  1  first sample of frame (qualified by valid_i)
- eof_i  in  1  last sample of frame (qualified by valid_i)
- ctl_valid_o  out  1  registered valid_i, asserted only while the frame is accepted
- ctl_chan_o  out  CW=max(1,$clog2(CHANNEL_NUM))  channel index of the sample
- acc_load_o  out  1  col_in_win==0: datapath loads the sample, not the running max
- lb_rd_o  out  1  col_in_win==K-1 && row_in_win!=0: merge with line-buffer entry
- lb_wr_o  out  1  col_in_win==K-1 && row_in_win!=K-1: store partial max
- lb_addr_o  out  LBW=$clog2((IMG_WIDTH/POOL_K)*CHANNEL_NUM)  (col/K)*CHANNEL_NUM+chan
- emit_o  out  1  sample completes a window: result is a pooled output
- sop_o, eop_o, sof_o, eof_o  out  1 each  output framing, qualified by emit_o
- frame_done_o  out  1  one-cycle pulse after a correctly sized frame
- err_o  out  1  sticky framing error; cleared by the next accepted sof_i

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN on valid_i&sof_i. Samples in IDLE without sof_i are dropped: ctl_valid_o stays 0.
  - RUN → IDLE on valid_i&eof_i.
- Counters advance only on accepted valid_i.
  - chan wraps 0..C-1.
  - col advances on chan wrap and wraps 0..W-1.
  - row advances on col wrap and wraps 0..H-1.
  - col_in_win and row_in_win wrap at K-1 in step with col and row.
- The sof sample is position (0,0,0) regardless of prior counter state.
- Remainder region (col ≥ (W/K)·K or row ≥ (H/K)·K) is dropped by floor semantics. In that region acc_load_o, lb_rd_o, lb_wr_o and emit_o are 0; ctl_valid_o and ctl_chan_o still track.
- emit_o = col_in_win==K-1 && row_in_win==K-1, outside the remainder region.
- Output framing, all gated by emit_o:
  - sop_o: output column 0 and chan 0.
  - eop_o: last output column (W/K-1) and chan C-1.
  - sof_o: output row 0, output column 0, chan 0.
  - eof_o: last output row, last output column, chan C-1.
- Error cases:
  - eof_i arrives at a position other than (C-1, W-1, H-1): err_o set, FSM → IDLE, no frame_done_o.
  - Position (C-1, W-1, H-1) reached without eof_i: err_o set, FSM → IDLE. Following samples are dropped until sof_i.
  - sof_i during RUN: err_o set and counters restart at that sample. err_o is not cleared by this restart sof.
- frame_done_o pulses on a correct eof only.

## Timing
- Latency is 1 cycle. Sample accepted at edge n produces all ctl/framing outputs at edge n+1. The datapath delays data_i by 1 register to align.
- valid_i gaps hold all counters and force every strobe output to 0.
- Back-to-back frames: sof_i on the cycle after eof_i is accepted with no bubble.
- Simultaneous sof_i&eof_i (1-sample frame) is legal only if C=W=H=K=1, which is outside the parameter range, so it is flagged err_o.
- Reset values: FSM IDLE, all counters 0, every output 0 including err_o and lb_addr_o.
- Reset mid-frame aborts immediately. The next frame must start with sof_i.

## Structure
- Shared package pool_pkg holds:
  - the state enum typedef {IDLE, RUN};
  - functions for the CW and LBW width calculation, reused by the max-pool datapaths.
- One sub-module, wrap_counter (parameter MAX, inputs inc and clr, outputs cnt and last), instanced five times: chan, col, row, col_in_win, row_in_win.
- lb_addr_o is an incremental register: reset on row start, +1 per chan, back to the group base during a window column. It uses no multiplier.

## Test plan
- C=3,W=4,H=4,K=2, one continuous frame:
  - emit_o ×12;
  - sop_o ×2 and eop_o ×2;
  - sof_o at output (0,0,0) and eof_o at output (1,1,2);
  - frame_done_o once, err_o 0.
- Same frame with random valid_i gaps → identical ctl output sequence once gaps are removed.
- W=5,H=5,K=2,C=1:
  - emit_o ×4;
  - column 4 and row 4 samples give ctl_valid_o=1 and all strobes 0.
- eof_i at sample 20 of a 48-sample frame → err_o=1 from the next cycle. FSM is IDLE and the remaining samples give ctl_valid_o=0. The next sof_i clears err_o.
- sof_i mid-frame at sample 10 → err_o=1 and ctl_chan_o=0, with counters restarted at that sample.
- reset_n low during sample 30 → all outputs 0 within the reset. After release, samples without sof_i are ignored.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and width helpers for the max-pool window sequencer and its datapaths.
package pool_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    function automatic int unsigned chan_w(input int unsigned chans);
        return (chans > 1) ? $clog2(chans) : 1;
    endfunction

    function automatic int unsigned lb_addr_w(input int unsigned width,
                                              input int unsigned k,
                                              input int unsigned chans);
        int unsigned depth;
        depth = (width / k) * chans;
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter; clr zeroes the current value so an increment in the same cycle starts from 0.
module wrap_counter
    import pool_pkg::*;
#(
    parameter int unsigned MAX = 1,
    localparam int unsigned CNT_W = cnt_w(MAX)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt  = clr ? '0 : cnt_q;
        last = (cnt == CNT_W'(MAX));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= last ? '0 : cnt + CNT_W'(1);
        end else if (clr) begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/pool_window_ctrl.sv
// Position tracker and control-strobe generator for a streaming KxK max-pool stage.
module pool_window_ctrl
    import pool_pkg::*;
#(
    parameter int unsigned CHANNEL_NUM = 3,
    parameter int unsigned IMG_WIDTH   = 8,
    parameter int unsigned IMG_HEIGHT  = 8,
    parameter int unsigned POOL_K      = 2,
    localparam int unsigned CW  = chan_w(CHANNEL_NUM),
    localparam int unsigned LBW = lb_addr_w(IMG_WIDTH, POOL_K, CHANNEL_NUM)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           valid_i,
    input  logic           sof_i,
    input  logic           eof_i,
    output logic           ctl_valid_o,
    output logic [CW-1:0]  ctl_chan_o,
    output logic           acc_load_o,
    output logic           lb_rd_o,
    output logic           lb_wr_o,
    output logic [LBW-1:0] lb_addr_o,
    output logic           emit_o,
    output logic           sop_o,
    output logic           eop_o,
    output logic           sof_o,
    output logic           eof_o,
    output logic           frame_done_o,
    output logic           err_o
);

    localparam int unsigned COL_W       = cnt_w(IMG_WIDTH - 1);
    localparam int unsigned ROW_W       = cnt_w(IMG_HEIGHT - 1);
    localparam int unsigned WIN_W       = cnt_w(POOL_K - 1);
    localparam int unsigned USED_COLS   = (IMG_WIDTH / POOL_K) * POOL_K;
    localparam int unsigned USED_ROWS   = (IMG_HEIGHT / POOL_K) * POOL_K;

    state_e           state_q, state_d;
    logic             acc, sof_acc;
    logic [CW-1:0]    chan;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [WIN_W-1:0] col_win, row_win;
    logic             chan_last, col_last, row_last, col_win_last, row_win_last;
    logic             is_last, in_rem, win_ok, emit;
    logic [LBW-1:0]   addr_q, base_q, addr_d, base_d, s_addr, s_base;
    logic             err_d, done_d;

    assign acc     = valid_i && ((state_q == RUN) || sof_i);
    assign sof_acc = acc && sof_i;

    wrap_counter #(.MAX(CHANNEL_NUM - 1)) u_chan (
        .clk(clk), .reset_n(reset_n), .inc(acc), .clr(sof_acc),
        .cnt(chan), .last(chan_last)
    );

    wrap_counter #(.MAX(IMG_WIDTH - 1)) u_col (
        .clk(clk), .reset_n(reset_n), .inc(acc && chan_last), .clr(sof_acc),
        .cnt(col), .last(col_last)
    );

    wrap_counter #(.MAX(IMG_HEIGHT - 1)) u_row (
        .clk(clk), .reset_n(reset_n), .inc(acc && chan_last && col_last), .clr(sof_acc),
        .cnt(row), .last(row_last)
    );

    // Window phases are forced to 0 at the line/frame start so a ragged width or height realigns them.
    wrap_counter #(.MAX(POOL_K - 1)) u_col_win (
        .clk(clk), .reset_n(reset_n), .inc(acc && chan_last), .clr(sof_acc || (col == '0)),
        .cnt(col_win), .last(col_win_last)
    );

    wrap_counter #(.MAX(POOL_K - 1)) u_row_win (
        .clk(clk), .reset_n(reset_n), .inc(acc && chan_last && col_last),
        .clr(sof_acc || (row == '0)),
        .cnt(row_win), .last(row_win_last)
    );

    assign is_last = chan_last && col_last && row_last;
    assign in_rem  = (32'(col) >= USED_COLS) || (32'(row) >= USED_ROWS);
    assign win_ok  = acc && !in_rem;
    assign emit    = win_ok && col_win_last && row_win_last;
    assign s_addr  = sof_acc ? '0 : addr_q;
    assign s_base  = sof_acc ? '0 : base_q;

    // Line-buffer address walks the channels, rewinds within a window column, advances per window group.
    always_comb begin
        addr_d = addr_q;
        base_d = base_q;
        if (acc) begin
            if (!chan_last) begin
                addr_d = s_addr + LBW'(1);
                base_d = s_base;
            end else if (col_last) begin
                addr_d = '0;
                base_d = '0;
            end else if (col_win_last) begin
                addr_d = s_addr + LBW'(1);
                base_d = s_addr + LBW'(1);
            end else begin
                addr_d = s_base;
                base_d = s_base;
            end
        end
    end

    // Frame FSM and error/done qualification of each accepted sample.
    always_comb begin
        state_d = state_q;
        err_d   = err_o;
        done_d  = 1'b0;
        if (acc) begin
            state_d = (eof_i || is_last) ? IDLE : RUN;
            done_d  = eof_i && is_last;
            if (sof_i) begin
                err_d = 1'b0;
            end
            if ((sof_i && (state_q == RUN)) || (eof_i != is_last)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctl_valid_o  <= 1'b0;
            ctl_chan_o   <= '0;
            acc_load_o   <= 1'b0;
            lb_rd_o      <= 1'b0;
            lb_wr_o      <= 1'b0;
            lb_addr_o    <= '0;
            emit_o       <= 1'b0;
            sop_o        <= 1'b0;
            eop_o        <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
            frame_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            ctl_valid_o  <= acc;
            ctl_chan_o   <= acc ? chan : '0;
            acc_load_o   <= win_ok && (col_win == '0);
            lb_rd_o      <= win_ok && col_win_last && (row_win != '0);
            lb_wr_o      <= win_ok && col_win_last && !row_win_last;
            lb_addr_o    <= win_ok ? s_addr : '0;
            emit_o       <= emit;
            sop_o        <= emit && (col == COL_W'(POOL_K - 1)) && (chan == '0);
            eop_o        <= emit && (col == COL_W'(USED_COLS - 1)) && chan_last;
            sof_o        <= emit && (row == ROW_W'(POOL_K - 1)) && (col == COL_W'(POOL_K - 1))
                            && (chan == '0);
            eof_o        <= emit && (row == ROW_W'(USED_ROWS - 1)) && (col == COL_W'(USED_COLS - 1))
                            && chan_last;
            frame_done_o <= done_d;
            err_o        <= err_d;
        end
    end

endmodule

// File: tb/tb_pool_window_ctrl.sv
// Randomised bench for pool_window_ctrl against an arithmetic position model, two parameter sets.
module tb_pool_window_ctrl;

    localparam int unsigned A_C = 3, A_W = 4, A_H = 4, A_K = 2;
    localparam int unsigned B_C = 1, B_W = 5, B_H = 5, B_K = 2;

    typedef struct packed {
        logic       valid;
        logic [7:0] chan;
        logic       load;
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic       emit;
        logic       sop;
        logic       eop;
        logic       sof;
        logic       eof;
        logic       done;
        logic       err;
    } obs_t;

    logic clk;
    logic reset_n;
    logic a_valid, a_sof, a_eof, b_valid, b_sof, b_eof;

    logic       a_ctl_valid, a_load, a_rd, a_wr, a_emit, a_sop, a_eop, a_sof_o, a_eof_o, a_done, a_err;
    logic [1:0] a_chan;
    logic [2:0] a_addr;
    logic       b_ctl_valid, b_load, b_rd, b_wr, b_emit, b_sop, b_eop, b_sof_o, b_eof_o, b_done, b_err;
    logic [0:0] b_chan;
    logic [0:0] b_addr;

    int n_tests;
    int n_fail;

    pool_window_ctrl #(.CHANNEL_NUM(A_C), .IMG_WIDTH(A_W), .IMG_HEIGHT(A_H), .POOL_K(A_K)) dut_a (
        .clk(clk), .reset_n(reset_n), .valid_i(a_valid), .sof_i(a_sof), .eof_i(a_eof),
        .ctl_valid_o(a_ctl_valid), .ctl_chan_o(a_chan), .acc_load_o(a_load), .lb_rd_o(a_rd),
        .lb_wr_o(a_wr), .lb_addr_o(a_addr), .emit_o(a_emit), .sop_o(a_sop), .eop_o(a_eop),
        .sof_o(a_sof_o), .eof_o(a_eof_o), .frame_done_o(a_done), .err_o(a_err)
    );

    pool_window_ctrl #(.CHANNEL_NUM(B_C), .IMG_WIDTH(B_W), .IMG_HEIGHT(B_H), .POOL_K(B_K)) dut_b (
        .clk(clk), .reset_n(reset_n), .valid_i(b_valid), .sof_i(b_sof), .eof_i(b_eof),
        .ctl_valid_o(b_ctl_valid), .ctl_chan_o(b_chan), .acc_load_o(b_load), .lb_rd_o(b_rd),
        .lb_wr_o(b_wr), .lb_addr_o(b_addr), .emit_o(b_emit), .sop_o(b_sop), .eop_o(b_eop),
        .sof_o(b_sof_o), .eof_o(b_eof_o), .frame_done_o(b_done), .err_o(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t obs_a();
        obs_t o;
        o = '{valid: a_ctl_valid, chan: 8'(a_chan), load: a_load, rd: a_rd, wr: a_wr,
              addr: 8'(a_addr), emit: a_emit, sop: a_sop, eop: a_eop, sof: a_sof_o,
              eof: a_eof_o, done: a_done, err: a_err};
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o = '{valid: b_ctl_valid, chan: 8'(b_chan), load: b_load, rd: b_rd, wr: b_wr,
              addr: 8'(b_addr), emit: b_emit, sop: b_sop, eop: b_eop, sof: b_sof_o,
              eof: b_eof_o, done: b_done, err: b_err};
        return o;
    endfunction

    // Expected outputs for the n-th sample of a frame, from raster position arithmetic.
    function automatic obs_t model(input int c, input int w, input int h, input int k, input int n);
        obs_t m;
        int   chan, col, row, oc, orow;
        bit   rem;
        m    = '0;
        chan = n % c;
        col  = (n / c) % w;
        row  = (n / (c * w)) % h;
        rem  = (col >= (w / k) * k) || (row >= (h / k) * k);
        m.valid = 1'b1;
        m.chan  = 8'(chan);
        if (!rem) begin
            oc     = col / k;
            orow   = row / k;
            m.load = (col % k == 0);
            m.rd   = (col % k == k - 1) && (row % k != 0);
            m.wr   = (col % k == k - 1) && (row % k != k - 1);
            m.addr = 8'(oc * c + chan);
            m.emit = (col % k == k - 1) && (row % k == k - 1);
            m.sop  = m.emit && (oc == 0) && (chan == 0);
            m.eop  = m.emit && (oc == w / k - 1) && (chan == c - 1);
            m.sof  = m.emit && (orow == 0) && (oc == 0) && (chan == 0);
            m.eof  = m.emit && (orow == h / k - 1) && (oc == w / k - 1) && (chan == c - 1);
        end
        return m;
    endfunction

    // Drive one cycle on the selected instance and sample its outputs 1 ns after the edge.
    task automatic cycle(input bit which, input bit v, input bit s, input bit e, output obs_t o);
        a_valid = !which && v; a_sof = !which && s; a_eof = !which && e;
        b_valid = which && v;  b_sof = which && s;  b_eof = which && e;
        @(posedge clk);
        #1;
        o = which ? obs_b() : obs_a();
    endtask

    task automatic run_frame(input string tag, input bit which, input int gap_pct,
                             output int emits, output int sops, output int eops,
                             output int sof_at, output int eof_at, output int dones);
        int   c, w, h, k, total, n, cycles;
        bit   v;
        obs_t o, ex;
        c = which ? int'(B_C) : int'(A_C);
        w = which ? int'(B_W) : int'(A_W);
        h = which ? int'(B_H) : int'(A_H);
        k = which ? int'(B_K) : int'(A_K);
        total = c * w * h;
        n = 0; cycles = 0;
        emits = 0; sops = 0; eops = 0; sof_at = -1; eof_at = -1; dones = 0;
        while (n < total && cycles < 20 * total) begin
            v = (gap_pct == 0) || ($urandom_range(0, 99) >= 32'(gap_pct));
            cycle(which, v, v && (n == 0), v && (n == total - 1), o);
            ex = '0;
            if (v) begin
                ex      = model(c, w, h, k, n);
                ex.done = (n == total - 1);
            end
            n_tests++;
            if (o !== ex) begin
                $display("FAIL %s sample %0d: got %h expected %h", tag, n, o, ex);
                n_fail++;
            end
            if (v) begin
                if (o.emit) emits++;
                if (o.sop)  sops++;
                if (o.eop)  eops++;
                if (o.sof)  sof_at = n;
                if (o.eof)  eof_at = n;
                n++;
            end
            if (o.done) dones++;
            cycles++;
        end
        n_tests++;
        if (n != total) begin
            $display("FAIL %s_budget: reached %0d samples, required %0d", tag, n, total);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        obs_t oa, ob;
        oa = obs_a();
        ob = obs_b();
        n_tests++;
        if (oa !== '0) begin $display("FAIL reset_a: got %h expected 0", oa); n_fail++; end
        n_tests++;
        if (ob !== '0) begin $display("FAIL reset_b: got %h expected 0", ob); n_fail++; end
    endtask

    task automatic test_full_frame();
        int em, sp, ep, sa, ea, dn;
        obs_t o;
        run_frame("full", 1'b0, 0, em, sp, ep, sa, ea, dn);
        n_tests++; if (em != 12) begin $display("FAIL full_emits: got %0d expected 12", em); n_fail++; end
        n_tests++; if (sp != 2)  begin $display("FAIL full_sops: got %0d expected 2", sp); n_fail++; end
        n_tests++; if (ep != 2)  begin $display("FAIL full_eops: got %0d expected 2", ep); n_fail++; end
        n_tests++; if (sa != 15) begin $display("FAIL full_sof_at: got %0d expected 15", sa); n_fail++; end
        n_tests++; if (ea != 47) begin $display("FAIL full_eof_at: got %0d expected 47", ea); n_fail++; end
        n_tests++; if (dn != 1)  begin $display("FAIL full_done: got %0d expected 1", dn); n_fail++; end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, o);
        n_tests++;
        if (o !== '0) begin $display("FAIL full_idle: got %h expected 0", o); n_fail++; end
    endtask

    task automatic test_gaps();
        int em, sp, ep, sa, ea, dn;
        run_frame("gaps", 1'b0, 35, em, sp, ep, sa, ea, dn);
        n_tests++; if (em != 12) begin $display("FAIL gaps_emits: got %0d expected 12", em); n_fail++; end
        n_tests++; if (dn != 1)  begin $display("FAIL gaps_done: got %0d expected 1", dn); n_fail++; end
    endtask

    task automatic test_back_to_back();
        int em, sp, ep, sa, ea, dn1, dn2;
        run_frame("b2b_first", 1'b0, 0, em, sp, ep, sa, ea, dn1);
        run_frame("b2b_second", 1'b0, 0, em, sp, ep, sa, ea, dn2);
        n_tests++;
        if (dn1 + dn2 != 2) begin $display("FAIL b2b_done: got %0d expected 2", dn1 + dn2); n_fail++; end
        n_tests++;
        if (em != 12) begin $display("FAIL b2b_emits: got %0d expected 12", em); n_fail++; end
    endtask

    task automatic test_remainder();
        int em, sp, ep, sa, ea, dn;
        run_frame("rem", 1'b1, 0, em, sp, ep, sa, ea, dn);
        n_tests++; if (em != 4)  begin $display("FAIL rem_emits: got %0d expected 4", em); n_fail++; end
        n_tests++; if (sp != 2)  begin $display("FAIL rem_sops: got %0d expected 2", sp); n_fail++; end
        n_tests++; if (sa != 6)  begin $display("FAIL rem_sof_at: got %0d expected 6", sa); n_fail++; end
        n_tests++; if (ea != 18) begin $display("FAIL rem_eof_at: got %0d expected 18", ea); n_fail++; end
        n_tests++; if (dn != 1)  begin $display("FAIL rem_done: got %0d expected 1", dn); n_fail++; end
    endtask

    task automatic test_eof_early();
        int em, sp, ep, sa, ea, dn;
        obs_t o, ex;
        for (int n = 0; n < 20; n++) begin
            cycle(1'b0, 1'b1, n == 0, n == 19, o);
            ex = model(int'(A_C), int'(A_W), int'(A_H), int'(A_K), n);
            ex.err = (n == 19);
            n_tests++;
            if (o !== ex) begin $display("FAIL eof_early sample %0d: got %h expected %h", n, o, ex); n_fail++; end
        end
        for (int n = 20; n < 48; n++) begin
            cycle(1'b0, 1'b1, 1'b0, n == 47, o);
            ex = '0;
            ex.err = 1'b1;
            n_tests++;
            if (o !== ex) begin $display("FAIL eof_drop sample %0d: got %h expected %h", n, o, ex); n_fail++; end
        end
        run_frame("eof_recover", 1'b0, 0, em, sp, ep, sa, ea, dn);
        n_tests++; if (dn != 1) begin $display("FAIL eof_recover_done: got %0d expected 1", dn); n_fail++; end
    endtask

    task automatic test_sof_mid();
        int em, sp, ep, sa, ea, dn;
        obs_t o, ex;
        for (int n = 0; n < 10; n++) begin
            cycle(1'b0, 1'b1, n == 0, 1'b0, o);
            ex = model(int'(A_C), int'(A_W), int'(A_H), int'(A_K), n);
            n_tests++;
            if (o !== ex) begin $display("FAIL sof_mid_pre sample %0d: got %h expected %h", n, o, ex); n_fail++; end
        end
        for (int m = 0; m < 48; m++) begin
            cycle(1'b0, 1'b1, m == 0, m == 47, o);
            ex = model(int'(A_C), int'(A_W), int'(A_H), int'(A_K), m);
            ex.err  = 1'b1;
            ex.done = (m == 47);
            n_tests++;
            if (o !== ex) begin $display("FAIL sof_mid_restart sample %0d: got %h expected %h", m, o, ex); n_fail++; end
        end
        run_frame("sof_recover", 1'b0, 0, em, sp, ep, sa, ea, dn);
        n_tests++; if (dn != 1) begin $display("FAIL sof_recover_done: got %0d expected 1", dn); n_fail++; end
    endtask

    task automatic test_missing_eof();
        int em, sp, ep, sa, ea, dn;
        obs_t o, ex;
        for (int n = 0; n < 48; n++) begin
            cycle(1'b0, 1'b1, n == 0, 1'b0, o);
            ex = model(int'(A_C), int'(A_W), int'(A_H), int'(A_K), n);
            ex.err = (n == 47);
            n_tests++;
            if (o !== ex) begin $display("FAIL no_eof sample %0d: got %h expected %h", n, o, ex); n_fail++; end
        end
        for (int n = 0; n < 4; n++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, o);
            ex = '0;
            ex.err = 1'b1;
            n_tests++;
            if (o !== ex) begin $display("FAIL no_eof_drop cycle %0d: got %h expected %h", n, o, ex); n_fail++; end
        end
        run_frame("no_eof_recover", 1'b0, 0, em, sp, ep, sa, ea, dn);
        n_tests++; if (dn != 1) begin $display("FAIL no_eof_recover_done: got %0d expected 1", dn); n_fail++; end
    endtask

    task automatic test_reset_mid();
        int em, sp, ep, sa, ea, dn;
        obs_t o, ex;
        for (int n = 0; n < 30; n++) begin
            cycle(1'b0, 1'b1, n == 0, 1'b0, o);
            ex = model(int'(A_C), int'(A_W), int'(A_H), int'(A_K), n);
            n_tests++;
            if (o !== ex) begin $display("FAIL rst_mid_pre sample %0d: got %h expected %h", n, o, ex); n_fail++; end
        end
        a_valid = 1'b1; a_sof = 1'b0; a_eof = 1'b0;
        #3 reset_n = 1'b0;
        #1 o = obs_a();
        n_tests++;
        if (o !== '0) begin $display("FAIL rst_mid_async: got %h expected 0", o); n_fail++; end
        @(posedge clk);
        #1 o = obs_a();
        n_tests++;
        if (o !== '0) begin $display("FAIL rst_mid_hold: got %h expected 0", o); n_fail++; end
        reset_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, o);
            n_tests++;
            if (o !== '0) begin $display("FAIL rst_mid_drop cycle %0d: got %h expected 0", n, o); n_fail++; end
        end
        run_frame("rst_recover", 1'b0, 0, em, sp, ep, sa, ea, dn);
        n_tests++; if (dn != 1) begin $display("FAIL rst_recover_done: got %0d expected 1", dn); n_fail++; end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        a_valid = 1'b0; a_sof = 1'b0; a_eof = 1'b0;
        b_valid = 1'b0; b_sof = 1'b0; b_eof = 1'b0;
        #12;
        test_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        test_full_frame();
        test_gaps();
        test_back_to_back();
        test_remainder();
        test_eof_early();
        test_sof_mid();
        test_missing_eof();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
